// File: rtl/lutram_mport_init.sv
// Multi-read-port LUT RAM with a hardware clear sweep and a ready handshake.
// Optional write-first bypass on the read ports: define LUTRAM_MPORT_WR_BYPASS_EN.
module lutram_mport_init #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned data_width = 8,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 15,
  parameter int unsigned n_read     = 2,
  parameter logic [data_width-1:0] init_val = '0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           INIT_REQ,
  input  logic [addr_width-1:0]          ADDR_IN,
  input  logic [data_width-1:0]          D_IN,
  input  logic                           WE,
  input  logic [n_read*addr_width-1:0]   ADDR_R,
  output logic [n_read*data_width-1:0]   D_OUT,
  output logic                           RDY,
  output logic                           WR_DROP
);

  localparam int unsigned Depth = hi - lo + 1;
  localparam logic [addr_width-1:0] LoAddr  = addr_width'(lo);
  localparam logic [addr_width-1:0] HiAddr  = addr_width'(hi);
  localparam logic [addr_width:0]   LoExt   = (addr_width + 1)'(lo);
  localparam logic [addr_width:0]   SpanExt = (addr_width + 1)'(hi - lo);

  typedef enum logic {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;
  logic                    wr_drop_q, wr_drop_d;

  logic [data_width-1:0]   mem_q [Depth];
  logic                    mem_we;
  logic [addr_width-1:0]   mem_idx;
  logic [data_width-1:0]   mem_wdata;

  // Offset from lo computed one bit wider: an address below lo wraps to a large
  // value, so a single unsigned compare against the span covers both bounds.
  logic [addr_width:0]     wr_off;
  logic                    wr_in_rng;
  logic                    wr_ok;
  logic [addr_width-1:0]   cnt_off;

  always_comb begin
    wr_off    = {1'b0, ADDR_IN} - LoExt;
    wr_in_rng = (wr_off <= SpanExt);
    wr_ok     = (state_q == StReady) && WE && wr_in_rng;
    cnt_off   = cnt_q - LoAddr;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdy_d     = rdy_q;
    wr_drop_d = WE && !wr_ok;
    mem_we    = 1'b0;
    mem_idx   = wr_off[addr_width-1:0];
    mem_wdata = D_IN;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_off;
        mem_wdata = init_val;
        if (cnt_q == HiAddr) begin
          state_d = StReady;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        mem_we = wr_ok;
        // A write coinciding with INIT_REQ still lands; the sweep overwrites it.
        if (INIT_REQ) begin
          state_d = StInit;
          cnt_d   = LoAddr;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = LoAddr;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StInit;
      cnt_q     <= LoAddr;
      rdy_q     <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage deliberately has no reset: only the sweep initialises it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < n_read; k++) begin : g_rd
    logic [addr_width-1:0] rd_addr;
    logic [addr_width:0]   rd_off;
    logic                  rd_in_rng;
    logic [data_width-1:0] rd_data;

    always_comb begin
      rd_addr   = ADDR_R[k*addr_width +: addr_width];
      rd_off    = {1'b0, rd_addr} - LoExt;
      rd_in_rng = (rd_off <= SpanExt);
`ifdef LUTRAM_MPORT_WR_BYPASS_EN
      if (wr_ok && rd_in_rng && (rd_addr == ADDR_IN)) begin
        rd_data = D_IN;
      end else if (rdy_q && rd_in_rng) begin
        rd_data = mem_q[rd_off[addr_width-1:0]];
      end else begin
        rd_data = init_val;
      end
`else
      if (rdy_q && rd_in_rng) begin
        rd_data = mem_q[rd_off[addr_width-1:0]];
      end else begin
        rd_data = init_val;
      end
`endif
    end

    assign D_OUT[k*data_width +: data_width] = rd_data;
  end

  assign RDY     = rdy_q;
  assign WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_lutram_mport_init.sv
// Directed bench for lutram_mport_init: sweep timing, reads, dropped writes, re-init, bypass.
module tb_lutram_mport_init;

  logic        CLK;
  logic        RST;
  logic        INIT_REQ;
  logic [3:0]  ADDR_IN;
  logic [7:0]  D_IN;
  logic        WE;
  logic [7:0]  ADDR_R;
  logic [15:0] D_OUT;
  logic        RDY;
  logic        WR_DROP;

  // Second instance with hi=11 for the out-of-range write case.
  logic        init_req2;
  logic [3:0]  addr_in2;
  logic [7:0]  d_in2;
  logic        we2;
  logic [7:0]  addr_r2;
  logic [15:0] d_out2;
  logic        rdy2;
  logic        wr_drop2;

  int checks = 0;
  int errors = 0;

  lutram_mport_init dut (
    .CLK      (CLK),
    .RST      (RST),
    .INIT_REQ (INIT_REQ),
    .ADDR_IN  (ADDR_IN),
    .D_IN     (D_IN),
    .WE       (WE),
    .ADDR_R   (ADDR_R),
    .D_OUT    (D_OUT),
    .RDY      (RDY),
    .WR_DROP  (WR_DROP)
  );

  lutram_mport_init #(.hi(11)) dut11 (
    .CLK      (CLK),
    .RST      (RST),
    .INIT_REQ (init_req2),
    .ADDR_IN  (addr_in2),
    .D_IN     (d_in2),
    .WE       (we2),
    .ADDR_R   (addr_r2),
    .D_OUT    (d_out2),
    .RDY      (rdy2),
    .WR_DROP  (wr_drop2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] bp_exp;
    RST = 1'b0; INIT_REQ = 1'b0; ADDR_IN = '0; D_IN = '0; WE = 1'b0; ADDR_R = '0;
    init_req2 = 1'b0; addr_in2 = '0; d_in2 = '0; we2 = 1'b0; addr_r2 = '0;
    #1 RST = 1'b1;
    #2;
    chk("reset_rdy", 32'(RDY), 32'd0);
    chk("reset_drop", 32'(WR_DROP), 32'd0);
    chk("reset_dout", 32'(D_OUT), 32'h0000);
    step();
    RST = 1'b0;

    // Reset sweep, with a dropped write to addr 5 on edge 3.
    repeat (2) step();
    WE = 1'b1; ADDR_IN = 4'd5; D_IN = 8'hEE;
    step();
    WE = 1'b0;
    #1;
    chk("sweep_drop", 32'(WR_DROP), 32'd1);
    chk("sweep_rdy_e3", 32'(RDY), 32'd0);
    repeat (11) step();
    chk("sweep_rdy_e14", 32'(RDY), 32'd0);
    chk("sweep_drop_clr", 32'(WR_DROP), 32'd0);
    step();
    chk("sweep_rdy_e15", 32'(RDY), 32'd0);
    step();
    chk("sweep_rdy_e16", 32'(RDY), 32'd1);
    for (int a = 0; a < 16; a++) begin
      ADDR_R = {4'(15 - a), 4'(a)};
      #1;
      chk("sweep_read", 32'(D_OUT), 32'h0000);
    end

    // Write/read.
    WE = 1'b1; ADDR_IN = 4'd3; D_IN = 8'hA5;
    step();
    ADDR_IN = 4'd7; D_IN = 8'h5A;
    step();
    WE = 1'b0;
    chk("wr_no_drop", 32'(WR_DROP), 32'd0);
    ADDR_R = {4'd7, 4'd3};
    #1;
    chk("rd_3_7", 32'(D_OUT), 32'h5AA5);
    ADDR_R = {4'd3, 4'd3};
    #1;
    chk("rd_3_3", 32'(D_OUT), 32'hA5A5);

    // Bypass: addr 4 holds 0x11, then 0x77 is written while port0 reads 4.
    WE = 1'b1; ADDR_IN = 4'd4; D_IN = 8'h11;
    step();
    D_IN = 8'h77; ADDR_R = {4'd3, 4'd4};
    #1;
`ifdef LUTRAM_MPORT_WR_BYPASS_EN
    bp_exp = 8'h77;
`else
    bp_exp = 8'h11;
`endif
    chk("bypass_same_cycle", 32'(D_OUT), {16'h0, 8'hA5, bp_exp});
    step();
    WE = 1'b0;
    #1;
    chk("bypass_after_edge", 32'(D_OUT), 32'hA577);

    // Out-of-range write on the hi=11 instance.
    chk("hi11_rdy", 32'(rdy2), 32'd1);
    we2 = 1'b1; addr_in2 = 4'd11; d_in2 = 8'h99;
    step();
    addr_in2 = 4'd12; d_in2 = 8'hC3;
    step();
    we2 = 1'b0;
    #1;
    chk("hi11_drop", 32'(wr_drop2), 32'd1);
    addr_r2 = {4'd12, 4'd11};
    #1;
    chk("hi11_read", 32'(d_out2), 32'h0099);
    step();
    chk("hi11_drop_clr", 32'(wr_drop2), 32'd0);

    // Re-init with a simultaneous write to addr 2; INIT_REQ mid-sweep is ignored.
    WE = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ADDR_IN = 4'(a); D_IN = 8'(8'h10 + a);
      step();
    end
    WE = 1'b0;
    ADDR_R = {4'd2, 4'd9};
    #1;
    chk("fill_read", 32'(D_OUT), 32'h1219);
    INIT_REQ = 1'b1; WE = 1'b1; ADDR_IN = 4'd2; D_IN = 8'h33; ADDR_R = {4'd2, 4'd2};
    step();
    INIT_REQ = 1'b0; WE = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("reinit_rdy", 32'(RDY), 32'd0);
      chk("reinit_dout", 32'(D_OUT), 32'h0000);
      INIT_REQ = (i == 5);
      step();
    end
    INIT_REQ = 1'b0;
    chk("reinit_done", 32'(RDY), 32'd1);
    for (int a = 0; a < 16; a++) begin
      ADDR_R = {4'(15 - a), 4'(a)};
      #1;
      chk("reinit_read", 32'(D_OUT), 32'h0000);
    end

    // Reset mid-sweep restarts from lo.
    INIT_REQ = 1'b1;
    step();
    INIT_REQ = 1'b0;
    repeat (6) step();
    RST = 1'b1;
    #1;
    chk("midrst_rdy", 32'(RDY), 32'd0);
    chk("midrst_drop", 32'(WR_DROP), 32'd0);
    step();
    RST = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      INIT_REQ = (i == 3);
      step();
      INIT_REQ = 1'b0;
      if (i == 15) chk("midrst_rdy_e15", 32'(RDY), 32'd0);
    end
    step();
    chk("midrst_rdy_e16", 32'(RDY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
